// File: rtl/main_mem_burst_if.sv
// Line-request bus between the data-cache controller (master) and the burst
// main memory (slave): request handshake, write-back beats and refill beats.
interface main_mem_burst_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [10:0] req_addr;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        wr_done;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, wr_data, wr_valid,
    input  req_ready, wr_ready, wr_done, rd_data, rd_valid, rd_last, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, wr_data, wr_valid,
    output req_ready, wr_ready, wr_done, rd_data, rd_valid, rd_last, busy
  );
endinterface

// File: rtl/main_mem_burst.sv
// Slow backing memory for the data cache: one line request at a time, refills
// stream LINE_WORDS words after LATENCY cycles, write-backs commit after LATENCY.
module main_mem_burst #(
  parameter int LINE_WORDS  = 4,
  parameter int LATENCY     = 4,
  parameter int DEPTH_WORDS = 512
) (
  input  logic             clk,
  input  logic             rst,
  main_mem_burst_if.slave  bus
);

  localparam int CNT_W  = $clog2(LINE_WORDS);
  localparam int AW     = $clog2(DEPTH_WORDS);
  localparam int LINE_W = AW - CNT_W;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATENCY - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RWAIT   = 3'd1;
  localparam logic [2:0] RBURST  = 3'd2;
  localparam logic [2:0] WBURST  = 3'd3;
  localparam logic [2:0] WCOMMIT = 3'd4;

  typedef logic [31:0] mem_t [DEPTH_WORDS];

  // Power-up content (word i holds i) so refills return known data before any write-back.
  function automatic mem_t mem_init();
    mem_t m;
    for (int i = 0; i < DEPTH_WORDS; i++) m[i] = 32'(i);
    return m;
  endfunction

  mem_t mem = mem_init();

  logic [2:0]        state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic              wr_done_q, wr_done_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [LINE_W-1:0] line_q, line_d;

  logic [AW-1:0]     word_addr;
  logic [31:0]       rd_word;
  logic              mem_we;
  logic              unused_addr_bits;

  // Line index plus in-line counter: a burst can never leave its own line.
  assign word_addr        = {line_q, wcnt_q};
  assign rd_word          = mem[word_addr];
  assign mem_we           = (state_q == WBURST) && bus.wr_valid && !rst;
  assign unused_addr_bits = ^bus.req_addr[CNT_W+1:0];

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    lat_d      = lat_q;
    line_d     = line_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    wr_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          line_d  = bus.req_addr[2+CNT_W +: LINE_W];
          wcnt_d  = '0;
          lat_d   = '0;
          state_d = bus.req_we ? WBURST : RWAIT;
        end
      end
      RWAIT: begin
        if (lat_q == LAT_LAST) begin
          state_d    = RBURST;
          rd_valid_d = 1'b1;
          rd_data_d  = rd_word;
          rd_last_d  = (wcnt_q == CNT_LAST);
          wcnt_d     = wcnt_q + CNT_W'(1);
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      RBURST: begin
        if (rd_last_q) begin
          state_d = IDLE;
        end else begin
          rd_valid_d = 1'b1;
          rd_data_d  = rd_word;
          rd_last_d  = (wcnt_q == CNT_LAST);
          wcnt_d     = wcnt_q + CNT_W'(1);
        end
      end
      WBURST: begin
        if (bus.wr_valid) begin
          wcnt_d = wcnt_q + CNT_W'(1);
          if (wcnt_q == CNT_LAST) begin
            state_d   = WCOMMIT;
            lat_d     = '0;
            wr_done_d = (LATENCY == 1);
          end
        end
      end
      WCOMMIT: begin
        // wr_done is raised on entry to the final commit cycle.
        if (lat_q == LAT_LAST) begin
          state_d = IDLE;
        end else begin
          lat_d     = lat_q + LAT_W'(1);
          wr_done_d = ((lat_q + LAT_W'(1)) == LAT_LAST);
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      wr_done_q   <= 1'b0;
      rd_data_q   <= '0;
      wcnt_q      <= '0;
      lat_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      wr_done_q   <= wr_done_d;
      rd_data_q   <= rd_data_d;
      wcnt_q      <= wcnt_d;
      lat_q       <= lat_d;
    end
    line_q <= line_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[word_addr] <= bus.wr_data;
  end

  assign bus.req_ready = req_ready_q;
  assign bus.wr_ready  = (state_q == WBURST);
  assign bus.wr_done   = wr_done_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
